// File: rtl/fetch_ctrl.sv
// Program counter, branch-target LUT and carry flag for the 9-bit CPU; IDLE/RUN/DONE framing.
// Latency: 1 cycle from sampled halt/branch/carry inputs to pc/carry_q/running/done.
// Backpressure: none; start is only honoured in IDLE, LUT writes only land in IDLE.
module fetch_ctrl #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              halt,
    input  logic              branch_en,
    input  logic              taken,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic              carry_out,
    input  logic              carry_we,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              carry_q,
    output logic              running,
    output logic              done
);

    localparam int              LUT_N  = 1 << LUT_AW;
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic              carry_nxt;
    logic              lut_wr;
    logic [PC_W-1:0]   lut [LUT_N];
    logic [PC_W-1:0]   lut_rd_dat;

    // Writes are confined to IDLE, so the combinational read never sees a same-cycle write.
    assign lut_rd_dat = lut[lut_idx];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            pc      <= '0;
            carry_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            carry_q <= carry_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_wr) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        carry_nxt = carry_q;
        lut_wr    = 1'b0;
        case (state)
            IDLE: begin
                pc_nxt = '0;
                lut_wr = lut_we;
                if (start) begin
                    state_nxt = RUN;
                    carry_nxt = 1'b0;
                end
            end
            RUN: begin
                // Halt freezes both pc and carry at the halting instruction.
                if (halt) begin
                    state_nxt = DONE;
                end else begin
                    if (branch_en && taken) begin
                        pc_nxt = lut_rd_dat;
                    end else begin
                        pc_nxt = pc + PC_ONE;
                    end
                    if (carry_we) begin
                        carry_nxt = carry_out;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                pc_nxt    = '0;
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = '0;
            end
        endcase
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural model predicts every cycle's outputs,
// plus directed checks of the addresses and flags the program scenarios should produce.
module tb_fetch_ctrl;

    localparam int PC_W   = 10;
    localparam int LUT_AW = 5;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              start = 1'b0;
    logic              halt = 1'b0;
    logic              branch_en = 1'b0;
    logic              taken = 1'b0;
    logic [LUT_AW-1:0] lut_idx = '0;
    logic              carry_out = 1'b0;
    logic              carry_we = 1'b0;
    logic              lut_we = 1'b0;
    logic [LUT_AW-1:0] lut_waddr = '0;
    logic [PC_W-1:0]   lut_wdata = '0;
    logic [PC_W-1:0]   pc;
    logic              carry_q;
    logic              running;
    logic              done;

    fetch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .halt      (halt),
        .branch_en (branch_en),
        .taken     (taken),
        .lut_idx   (lut_idx),
        .carry_out (carry_out),
        .carry_we  (carry_we),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .pc        (pc),
        .carry_q   (carry_q),
        .running   (running),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            carry;
        logic            running;
        logic            done;
    } exp_t;

    exp_t            exp_q[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              done_cnt = 0;

    // Reference model state: 0 idle, 1 run, 2 done.
    int              m_state = 0;
    logic [PC_W-1:0] m_pc = '0;
    logic            m_carry = 1'b0;
    logic [PC_W-1:0] m_lut [1 << LUT_AW];

    always @(negedge Clk) if (done) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = '0;
        m_carry = 1'b0;
        for (int i = 0; i < (1 << LUT_AW); i++) m_lut[i] = '0;
    endtask

    task automatic clear_inputs();
        start = 0; halt = 0; branch_en = 0; taken = 0; lut_idx = '0;
        carry_out = 0; carry_we = 0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    endtask

    // Predict, push, clock, pop and compare; inputs are one-shot per step.
    task automatic step();
        int              ns;
        logic [PC_W-1:0] npc;
        logic            nc;
        exp_t            e;
        exp_t            g;
        ns = m_state; npc = m_pc; nc = m_carry;
        if (m_state == 0) begin
            npc = '0;
            if (lut_we) m_lut[lut_waddr] = lut_wdata;
            if (start) begin ns = 1; nc = 1'b0; end
        end else if (m_state == 1) begin
            if (halt) ns = 2;
            else begin
                npc = (branch_en && taken) ? m_lut[lut_idx] : PC_W'((int'(m_pc) + 1) % (1 << PC_W));
                if (carry_we) nc = carry_out;
            end
        end else begin
            ns = 0; npc = '0;
        end
        m_state = ns; m_pc = npc; m_carry = nc;
        e.pc = npc; e.carry = nc; e.running = (ns == 1); e.done = (ns == 2);
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        g = exp_q.pop_front();
        chk("sb_pc", 32'(pc), 32'(g.pc));
        chk("sb_carry", 32'(carry_q), 32'(g.carry));
        chk("sb_running", 32'(running), 32'(g.running));
        chk("sb_done", 32'(done), 32'(g.done));
        clear_inputs();
    endtask

    task automatic lut_write(input int a, input int d);
        lut_we = 1; lut_waddr = LUT_AW'(a); lut_wdata = PC_W'(d);
        step();
    endtask

    task automatic branch(input int idx, input logic tk);
        branch_en = 1; taken = tk; lut_idx = LUT_AW'(idx);
        step();
    endtask

    initial begin
        model_reset();
        clear_inputs();
        Reset_n = 0;
        #12;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_carry", 32'(carry_q), 0);
        @(negedge Clk) Reset_n = 1;

        lut_write(3, 'h155);
        lut_write(9, 'h3FF);
        lut_write(4, 'h002);
        chk("idle_pc", 32'(pc), 0);

        // Sequential run then halt
        start = 1; step();
        chk("start_running", 32'(running), 1);
        chk("start_pc", 32'(pc), 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("seq_pc", 32'(pc), 32'(i));
        end
        halt = 1; step();
        chk("halt_done", 32'(done), 1);
        chk("halt_pc", 32'(pc), 5);
        chk("halt_running", 32'(running), 0);
        step();
        chk("post_done", 32'(done), 0);
        chk("post_pc", 32'(pc), 0);

        // Branch taken / not taken
        start = 1; step();
        step(); step();
        chk("pre_branch_pc", 32'(pc), 2);
        branch(3, 1'b1);
        chk("br_taken_pc", 32'(pc), 'h155);
        branch(4, 1'b1);
        chk("br_back_pc", 32'(pc), 2);
        branch(3, 1'b0);
        chk("br_not_taken_pc", 32'(pc), 3);
        taken = 1; step();
        chk("taken_no_en_pc", 32'(pc), 4);

        // Carry feedback, then halt priority over branch and carry
        carry_we = 1; carry_out = 1; step();
        chk("carry_set", 32'(carry_q), 1);
        halt = 1; branch_en = 1; taken = 1; lut_idx = 3; carry_we = 1; carry_out = 0;
        step();
        chk("prio_pc", 32'(pc), 5);
        chk("prio_done", 32'(done), 1);
        chk("prio_carry", 32'(carry_q), 1);
        start = 1; step();
        chk("done_start_ignored", 32'(running), 0);
        step();
        chk("idle_stays", 32'(running), 0);
        start = 1; step();
        chk("carry_cleared", 32'(carry_q), 0);

        // Wrap, ignored writes/starts during RUN
        branch(9, 1'b1);
        chk("br_max_pc", 32'(pc), 'h3FF);
        step();
        chk("wrap_pc", 32'(pc), 0);
        lut_we = 1; lut_waddr = 3; lut_wdata = 'h0AA; start = 1; step();
        chk("run_start_ignored", 32'(pc), 1);
        branch(3, 1'b1);
        chk("lut_unchanged", 32'(pc), 'h155);

        // Reset mid-RUN at pc 7
        branch(4, 1'b1);
        carry_we = 1; carry_out = 1; step();
        for (int i = 0; i < 4; i++) step();
        chk("pre_reset_pc", 32'(pc), 7);
        Reset_n = 0;
        #2;
        model_reset();
        chk("mid_rst_pc", 32'(pc), 0);
        chk("mid_rst_running", 32'(running), 0);
        chk("mid_rst_carry", 32'(carry_q), 0);
        chk("mid_rst_done", 32'(done), 0);
        @(negedge Clk) Reset_n = 1;
        start = 1; step();
        branch(3, 1'b1);
        chk("lut_cleared", 32'(pc), 0);
        halt = 1; step();
        step();
        @(negedge Clk);
        chk("done_pulses", 32'(done_cnt), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and control-flow stage of the 9-bit CPU, sitting directly downstream of the ALU. It consumes the ALU's `taken` and `carry_out` results and produces the next instruction address for instruction memory. It also holds the carry flag that feeds back to the ALU's `carry_in`. Branch targets come from a small internal lookup table, loaded before a program is started; a start/halt handshake frames each program run.

## Interface
Parameters:
- PC_W, 10, program-counter width (instruction memory depth 2^PC_W)
- LUT_AW, 5, branch-target LUT address width (2^LUT_AW entries of PC_W bits)

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin program execution at address 0
- halt  input  1  decoded halt instruction at current pc
- branch_en  input  1  current instruction is a conditional branch (pos/beq)
- taken  input  1  ALU branch condition result
- lut_idx  input  LUT_AW  branch-target LUT index from current instruction
- carry_out  input  1  ALU carry result
- carry_we  input  1  current instruction updates the carry flag
- lut_we  input  1  LUT write enable
- lut_waddr  input  LUT_AW  LUT write address
- lut_wdata  input  PC_W  LUT write data (branch target)
- pc  output  PC_W  current instruction address
- carry_q  output  1  carry flag, drives ALU carry_in
- running  output  1  high while in RUN
- done  output  1  one-cycle pulse when a program halts

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state.
- Reset (Reset_n low, asynchronous):
  - state=IDLE, pc=0, carry_q=0, running=0, done=0.
  - All LUT entries are cleared to 0.
  - Reset asserted mid-RUN aborts immediately; no done pulse is produced.
- IDLE:
  - pc holds 0.
  - lut_we=1 writes lut_wdata to entry lut_waddr.
  - start=1 → RUN on the next edge; carry_q cleared to 0 on the same edge; pc stays 0.
- RUN: evaluated each edge in priority order:
  1. halt=1 → DONE; pc holds; carry is not updated.
  2. branch_en=1 and taken=1 → pc = LUT[lut_idx].
  3. Otherwise pc = pc+1, modulo 2^PC_W (2^PC_W-1 wraps to 0).
- Carry flag in RUN, independent of the pc decision:
  - carry_we=1 and halt=0 → carry_q = carry_out.
  - Otherwise carry_q holds.
- DONE:
  - done=1 for exactly this one cycle.
  - Unconditional transition to IDLE on the next edge.
  - pc resets to 0 on entry to IDLE.
- Ignored inputs:
  - start while in RUN or DONE has no effect.
  - start must be re-asserted in IDLE to run again.
  - lut_we outside IDLE is ignored; the LUT is unchanged.
  - branch_en=0 with taken=1 is treated as sequential (pc+1).
  - taken with branch_en=1 and halt=1: halt wins.
- LUT reads are combinational from lut_idx; the write port and the read port never conflict, since writes occur only in IDLE.

## Timing
- start sampled at edge N → running=1 after edge N. The first instruction fetched at pc=0 is executed in cycle N+1.
- Branch/sequential latency: 1 cycle. The pc after edge K reflects the taken/branch_en/halt values sampled at edge K.
- ALU-to-ALU carry path: carry_out sampled at edge K is visible on carry_q, and therefore on ALU carry_in, in cycle K+1.
- Halt sampled at edge K:
  - After edge K: state=DONE, done=1, running=0.
  - After edge K+1: state=IDLE, done=0, pc=0.
- Minimum program run, start to done: start edge, one RUN cycle with halt, then done — done is high 2 cycles after start is sampled.
- No combinational path exists from any input to any output.

## Test plan
- Reset mid-RUN: start, advance pc to 7, pulse Reset_n low → pc=0, running=0, carry_q=0, done never asserted, LUT entry 3 reads 0.
- Sequential run and halt: start, hold branch_en=0 for 5 cycles, then halt=1 → pc goes 0,1,2,3,4,5; done pulses for 1 cycle; next cycle pc=0 and running=0.
- Branch taken/not taken: in IDLE write LUT[3]=0x155, then start.
  - At pc=2 with branch_en=1, taken=1, lut_idx=3 → next pc=0x155.
  - Repeat with taken=0 → next pc=3.
- Halt priority: branch_en=1, taken=1, halt=1 at the same edge → pc holds, done=1; carry_we=1 at the same edge leaves carry_q unchanged.
- Carry feedback and wrap: carry_we=1 with carry_out=1 → carry_q=1 the next cycle; a new start clears it to 0. Force pc=0x3FF via a branch → next sequential pc=0x000.
- Ignored writes/starts: lut_we=1 during RUN does not change LUT contents; start pulses during RUN and DONE do not restart execution, and pc continues normally.
